cache_mem_arbiter: RTL and testbench

- Shares one single-ported main-memory interface between the instruction-cache refill path and the data-cache refill/write-back path.
- Sits between both cache controllers and main memory. Each cache raises a line request; the arbiter grants one requester, sequences LINE_WORDS word transfers, then pulses done.
- Round-robin arbitration prevents I-side starvation during D-side miss storms.
- busy feeds the hazard unit as the global memory-stall indication.

---
 rtl/cache_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between I-cache refills
// and D-cache refills/write-backs, one cache line per grant.
module cache_mem_arbiter #(
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 2
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_rvalid,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_wready,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   output logic        d_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {IDLE, XFER_I, XFER_D, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_base;
   logic             r_we;
   logic             r_last_d;   // last granted side, also the side owning XFER/DONE
   logic             w_grant_i;
   logic             w_grant_d;
   logic             w_step;
   logic             w_last_word;
   logic [31:0]      w_addr;

   assign w_last_word = (r_cnt == LAST_CNT);
   assign w_addr      = r_base + {{(30-CNT_W){1'b0}}, r_cnt, 2'b00};

   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // The counter holds on the last word so the address never runs past the line.
   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         r_cnt    <= '0;
         r_base   <= '0;
         r_we     <= 1'b0;
         r_last_d <= 1'b0;
      end else if (w_grant_i) begin
         r_cnt    <= '0;
         r_base   <= i_addr;
         r_we     <= 1'b0;
         r_last_d <= 1'b0;
      end else if (w_grant_d) begin
         r_cnt    <= '0;
         r_base   <= d_addr;
         r_we     <= d_we;
         r_last_d <= 1'b1;
      end else if (w_step && !w_last_word) begin
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      w_step    = 1'b0;
      i_rdata   = '0;
      i_rvalid  = 1'b0;
      i_done    = 1'b0;
      d_wready  = 1'b0;
      d_rdata   = '0;
      d_rvalid  = 1'b0;
      d_done    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b1;
      grant     = 2'b00;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            // On a tie the side that did not win last time goes first.
            if (i_req && (!d_req || r_last_d)) begin
               w_grant_i = 1'b1;
               w_next    = XFER_I;
            end else if (d_req) begin
               w_grant_d = 1'b1;
               w_next    = XFER_D;
            end
         end
         XFER_I: begin
            grant    = 2'b01;
            mem_req  = 1'b1;
            mem_addr = w_addr;
            w_step   = mem_ack;
            if (mem_ack) begin
               i_rvalid = 1'b1;
               i_rdata  = mem_rdata;
               if (w_last_word) w_next = DONE;
            end
         end
         XFER_D: begin
            grant     = 2'b10;
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_addr  = w_addr;
            mem_wdata = r_we ? d_wdata : 32'h0;
            w_step    = mem_ack;
            if (mem_ack) begin
               if (r_we) begin
                  d_wready = 1'b1;
               end else begin
                  d_rvalid = 1'b1;
                  d_rdata  = mem_rdata;
               end
               if (w_last_word) w_next = DONE;
            end
         end
         DONE: begin
            grant  = {r_last_d, ~r_last_d};
            d_done = r_last_d;
            i_done = ~r_last_d;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change just after the falling
// edge and outputs are checked 1ns later, well clear of the rising edge.
module tb_cache_mem_arbiter;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RST;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_rvalid;
   logic        i_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_wready;
   logic [31:0] d_rdata;
   logic        d_rvalid;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        busy;
   logic [1:0]  grant;

   int total = 0;
   int bad   = 0;

   cache_mem_arbiter #(.LINE_WORDS(4), .CNT_W(2)) dut (
      .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .grant(grant)
   );

   always #5 CPU_CLK = ~CPU_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
   endtask

   // One line with mem_ack every cycle, first word on the cycle after the grant
   // edge, followed by the DONE cycle. Optionally drops d_req after word 0.
   task automatic xfer_line(input logic side_d, input logic we, input logic [31:0] base,
                            input logic [31:0] dat, input logic abort);
      for (int w = 0; w < 4; w++) begin
         @(negedge CPU_CLK);
         mem_ack   = 1'b1;
         mem_rdata = dat + 32'(w);
         d_wdata   = dat + 32'(w);
         #1;
         chk("line_mem_req", 32'(mem_req), 32'd1);
         chk("line_addr", mem_addr, base + 32'(4 * w));
         chk("line_we", 32'(mem_we), 32'(we));
         chk("line_grant", 32'(grant), side_d ? 32'd2 : 32'd1);
         if (side_d && we) begin
            chk("line_wready", 32'(d_wready), 32'd1);
            chk("line_wdata", mem_wdata, dat + 32'(w));
         end else if (side_d) begin
            chk("line_d_rvalid", 32'(d_rvalid), 32'd1);
            chk("line_d_rdata", d_rdata, dat + 32'(w));
            chk("line_i_rvalid", 32'(i_rvalid), 32'd0);
         end else begin
            chk("line_i_rvalid", 32'(i_rvalid), 32'd1);
            chk("line_i_rdata", i_rdata, dat + 32'(w));
            chk("line_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("line_i_wdata", mem_wdata, 32'd0);
         end
         if (abort && w == 0) d_req = 1'b0;
      end
      @(negedge CPU_CLK);
      mem_ack = 1'b0;
      #1;
      chk("done_mem_req", 32'(mem_req), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_grant", 32'(grant), side_d ? 32'd2 : 32'd1);
      chk("done_i", 32'(i_done), 32'(!side_d));
      chk("done_d", 32'(d_done), 32'(side_d));
   endtask

   initial begin
      CPU_RST   = 1'b1;
      i_req     = 1'b0;
      i_addr    = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;

      // Reset state
      @(negedge CPU_CLK);
      #1;
      chk_idle("rst");
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_outs", {i_rdata[15:0], d_rdata[15:0]}, 32'd0);
      chk("rst_pulses", 32'({i_rvalid, i_done, d_rvalid, d_done, d_wready}), 32'd0);
      CPU_RST = 1'b0;

      // I-side refill at 0x100
      @(negedge CPU_CLK);
      i_req  = 1'b1;
      i_addr = 32'h100;
      #1;
      chk_idle("i_pre");
      xfer_line(1'b0, 1'b0, 32'h100, 32'hA0, 1'b0);
      i_req = 1'b0;
      @(negedge CPU_CLK);
      #1;
      chk_idle("i_post");

      // Spurious ack while idle
      mem_ack   = 1'b1;
      mem_rdata = 32'hEE;
      #1;
      chk("spur_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("spur_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("spur_i_rdata", i_rdata, 32'd0);
      @(negedge CPU_CLK);
      mem_ack = 1'b0;
      #1;
      chk_idle("spur_post");
      chk("spur_done", 32'({i_done, d_done}), 32'd0);

      // D write-back at 0x2000 with three wait cycles per word
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h2000;
      d_wdata = 32'hD0;
      for (int w = 0; w < 4; w++) begin
         for (int s = 0; s < 3; s++) begin
            @(negedge CPU_CLK);
            mem_ack = 1'b0;
            d_wdata = 32'hD0 + 32'(w);
            if (w == 1) d_addr = 32'hFFF0;
            #1;
            chk("wb_wait_req", 32'(mem_req), 32'd1);
            chk("wb_wait_we", 32'(mem_we), 32'd1);
            chk("wb_wait_addr", mem_addr, 32'h2000 + 32'(4 * w));
            chk("wb_wait_wready", 32'(d_wready), 32'd0);
            chk("wb_wait_wdata", mem_wdata, 32'hD0 + 32'(w));
         end
         @(negedge CPU_CLK);
         mem_ack = 1'b1;
         #1;
         chk("wb_ack_wready", 32'(d_wready), 32'd1);
         chk("wb_ack_rvalid", 32'(d_rvalid), 32'd0);
         chk("wb_ack_addr", mem_addr, 32'h2000 + 32'(4 * w));
      end
      @(negedge CPU_CLK);
      mem_ack = 1'b0;
      #1;
      chk("wb_done", 32'(d_done), 32'd1);
      chk("wb_done_req", 32'(mem_req), 32'd0);
      d_req = 1'b0;
      d_we  = 1'b0;
      @(negedge CPU_CLK);
      #1;
      chk_idle("wb_post");

      // Fresh reset, then simultaneous requests: D first, then I, then D, I again
      CPU_RST = 1'b1;
      #1;
      chk_idle("tie_rst");
      @(negedge CPU_CLK);
      CPU_RST = 1'b0;
      i_req   = 1'b1;
      i_addr  = 32'h400;
      d_req   = 1'b1;
      d_addr  = 32'h500;
      xfer_line(1'b1, 1'b0, 32'h500, 32'hB0, 1'b0);
      d_req = 1'b0;
      @(negedge CPU_CLK);
      #1;
      chk_idle("tie_gap1");
      xfer_line(1'b0, 1'b0, 32'h400, 32'hC0, 1'b0);
      d_req  = 1'b1;
      d_addr = 32'h540;
      @(negedge CPU_CLK);
      #1;
      chk_idle("tie_gap2");
      xfer_line(1'b1, 1'b0, 32'h540, 32'hB4, 1'b0);
      d_req = 1'b0;
      @(negedge CPU_CLK);
      #1;
      chk_idle("tie_gap3");
      xfer_line(1'b0, 1'b0, 32'h400, 32'hC4, 1'b0);
      i_req = 1'b0;

      // D read abandoned after the first word still completes
      @(negedge CPU_CLK);
      #1;
      chk_idle("abort_pre");
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h600;
      xfer_line(1'b1, 1'b0, 32'h600, 32'h60, 1'b1);
      i_req  = 1'b1;
      i_addr = 32'h700;
      @(negedge CPU_CLK);
      #1;
      chk_idle("abort_gap");
      xfer_line(1'b0, 1'b0, 32'h700, 32'h70, 1'b0);
      i_req = 1'b0;

      // Reset during word 2 of an I refill
      @(negedge CPU_CLK);
      #1;
      chk_idle("mid_pre");
      i_req  = 1'b1;
      i_addr = 32'h800;
      for (int w = 0; w < 2; w++) begin
         @(negedge CPU_CLK);
         mem_ack = 1'b1;
         #1;
         chk("mid_addr", mem_addr, 32'h800 + 32'(4 * w));
      end
      @(negedge CPU_CLK);
      mem_ack = 1'b0;
      #1;
      chk("mid_addr2", mem_addr, 32'h808);
      CPU_RST = 1'b1;
      #1;
      chk_idle("mid_rst");
      chk("mid_rst_done", 32'(i_done), 32'd0);
      @(negedge CPU_CLK);
      CPU_RST = 1'b0;
      i_addr  = 32'h300;
      #1;
      chk_idle("mid_rel");
      xfer_line(1'b0, 1'b0, 32'h300, 32'h30, 1'b0);
      i_req = 1'b0;
      @(negedge CPU_CLK);
      #1;
      chk_idle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
